// File: rtl/shift_add_mult_if.sv
// Handshake/operand/result bundle for shift_add_mult. The multiplier owns the
// slave side; whoever issues operations and consumes the product owns the master side.
interface shift_add_mult_if #(
  parameter int N = 8
);
  logic           start;
  logic [N-1:0]   a;
  logic [N-1:0]   b;
  logic           busy;
  logic           done;
  logic [2*N-1:0] p;

  modport master (
    output start, a, b,
    input  busy, done, p
  );

  modport slave (
    input  start, a, b,
    output busy, done, p
  );
endinterface

// File: rtl/shift_add_mult.sv
// Sequential unsigned N x N shift-and-add multiplier, one partial product per clock,
// registered 2N-bit product with a one-cycle done pulse.
// Optional: define SHIFT_ADD_MULT_EARLY_EXIT_EN to stop once the multiplier runs out of set bits.
module shift_add_mult #(
  parameter int N = 8
) (
  input  logic           clk,
  input  logic           rest,
  shift_add_mult_if.slave bus
);

  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(N - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e         state_q, state_d;
  logic [2*N-1:0] mcand_q, mcand_d;
  logic [N-1:0]   mplr_q,  mplr_d;
  logic [2*N-1:0] acc_q,   acc_d;
  logic [CW-1:0]  cnt_q,   cnt_d;
  logic [2*N-1:0] p_q,     p_d;

  logic [2*N-1:0] acc_sum;
  logic [N-1:0]   mplr_shift;
  logic           last_iter;

  // Datapath for the current RUN iteration; the sum cannot exceed 2N bits for N x N.
  assign acc_sum    = mplr_q[0] ? (acc_q + mcand_q) : acc_q;
  assign mplr_shift = mplr_q >> 1;

`ifdef SHIFT_ADD_MULT_EARLY_EXIT_EN
  assign last_iter  = (cnt_q == LAST_CNT) || (mplr_shift == '0);
`else
  assign last_iter  = (cnt_q == LAST_CNT);
`endif

  always_comb begin
    // NOTE: every next-state value defaults to its hold value first, so no path
    // through the case can leave a signal unassigned and infer a latch.
    state_d = state_q;
    mcand_d = mcand_q;
    mplr_d  = mplr_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    p_d     = p_q;

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          mcand_d = {{N{1'b0}}, bus.a};
          mplr_d  = bus.b;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = RUN;
        end
      end

      RUN: begin
        acc_d   = acc_sum;
        mcand_d = mcand_q << 1;
        mplr_d  = mplr_shift;
        cnt_d   = cnt_q + 1'b1;
        if (last_iter) begin
          p_d     = acc_sum;
          state_d = DONE;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rest) begin
    if (rest) begin
      state_q <= IDLE;
      mcand_q <= '0;
      mplr_q  <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      p_q     <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the pre-edge
      // values computed above, independent of statement order.
      state_q <= state_d;
      mcand_q <= mcand_d;
      mplr_q  <= mplr_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      p_q     <= p_d;
    end
  end

  // Outputs decode from registers only; nothing combinational reaches them from inputs.
  assign bus.busy = (state_q != IDLE);
  assign bus.done = (state_q == DONE);
  assign bus.p    = p_q;

endmodule

// File: tb/tb_shift_add_mult.sv
// Directed self-checking bench for shift_add_mult (N=8); expected early-exit latencies
// follow SHIFT_ADD_MULT_EARLY_EXIT_EN when the bench is built with it.
module tb_shift_add_mult;

  localparam int N = 8;
  localparam int BUDGET = 40;

  logic clk;
  logic rest;
  int   checks;
  int   failures;

  shift_add_mult_if #(.N(N)) bus ();

  shift_add_mult #(.N(N)) dut (
    .clk  (clk),
    .rest (rest),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1 ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [N-1:0] a, input logic [N-1:0] b);
    bus.start = 1'b1;
    bus.a     = a;
    bus.b     = b;
    tick();
    bus.start = 1'b0;
    bus.a     = 8'hA5;
    bus.b     = 8'h5A;
  endtask

  // Counts edges until done is seen high; returns the budget on timeout.
  task automatic wait_done(output int cyc);
    cyc = 0;
    while (bus.done !== 1'b1 && cyc < BUDGET) begin
      tick();
      cyc++;
    end
  endtask

  task automatic test_reset();
    rest      = 1'b1;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    #3;
    checks++;
    if ({bus.busy, bus.done, bus.p} !== 18'd0) begin
      failures++;
      $display("FAIL reset_state: busy=%b done=%b p=%0d, required 0 0 0", bus.busy, bus.done, bus.p);
    end
    tick();
    tick();
    rest = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    int cyc;
    issue(8'd13, 8'd11);
    checks++;
    if (bus.busy !== 1'b1) begin
      failures++;
      $display("FAIL basic_busy: busy=%b, required 1", bus.busy);
    end
    wait_done(cyc);
    checks++;
    if (cyc != 8) begin
      failures++;
      $display("FAIL basic_latency: cycles=%0d, required 8", cyc);
    end
    checks++;
    if (bus.p !== 16'd143) begin
      failures++;
      $display("FAIL basic_product: p=%0d, required 143", bus.p);
    end
    tick();
    checks++;
    if ({bus.done, bus.busy, bus.p} !== {1'b0, 1'b0, 16'd143}) begin
      failures++;
      $display("FAIL basic_hold: done=%b busy=%b p=%0d, required 0 0 143", bus.done, bus.busy, bus.p);
    end
  endtask

  task automatic test_back_to_back();
    int cyc;
    int gap;
    issue(8'd255, 8'd255);
    wait_done(cyc);
    checks++;
    if (cyc != 8 || bus.p !== 16'hFE01) begin
      failures++;
      $display("FAIL max_product: cycles=%0d p=%h, required 8 fe01", cyc, bus.p);
    end
    bus.start = 1'b1;
    bus.a     = 8'd0;
    bus.b     = 8'd200;
    tick();
    tick();
    bus.start = 1'b0;
    wait_done(cyc);
    gap = 2 + cyc;
    checks++;
    if (gap != 10 || bus.p !== 16'd0) begin
      failures++;
      $display("FAIL back_to_back: gap=%0d p=%0d, required 10 0", gap, bus.p);
    end
    tick();
  endtask

  task automatic test_start_while_busy();
    int cyc;
    int gap;
    bus.start = 1'b1;
    bus.a     = 8'd3;
    bus.b     = 8'd5;
    tick();
    bus.a = 8'd7;
    bus.b = 8'd7;
    wait_done(cyc);
    checks++;
    if (cyc != 8 || bus.p !== 16'd15) begin
      failures++;
      $display("FAIL busy_ignore: cycles=%0d p=%0d, required 8 15", cyc, bus.p);
    end
    tick();
    wait_done(cyc);
    gap = 1 + cyc;
    checks++;
    if (gap != 10 || bus.p !== 16'd49) begin
      failures++;
      $display("FAIL busy_held_start: gap=%0d p=%0d, required 10 49", gap, bus.p);
    end
    bus.start = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid_run();
    int cyc;
    int dones;
    issue(8'd200, 8'd3);
    tick();
    tick();
    tick();
    #1 rest = 1'b1;
    #1;
    checks++;
    if ({bus.busy, bus.done, bus.p} !== 18'd0) begin
      failures++;
      $display("FAIL reset_abort: busy=%b done=%b p=%0d, required 0 0 0", bus.busy, bus.done, bus.p);
    end
    #1 rest = 1'b0;
    dones = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (bus.done === 1'b1) dones++;
    end
    checks++;
    if (dones != 0 || bus.p !== 16'd0 || bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_no_done: dones=%0d p=%0d busy=%b, required 0 0 0", dones, bus.p, bus.busy);
    end
    issue(8'd2, 8'd9);
    wait_done(cyc);
    checks++;
    if (cyc != 8 || bus.p !== 16'd18) begin
      failures++;
      $display("FAIL reset_restart: cycles=%0d p=%0d, required 8 18", cyc, bus.p);
    end
    tick();
  endtask

  task automatic test_reset_values();
    int bad;
    bad  = 0;
    rest = 1'b1;
    for (int i = 0; i < 6; i++) begin
      bus.start = i[0];
      bus.a     = 8'(i + 1);
      bus.b     = 8'd3;
      tick();
      if ({bus.busy, bus.done, bus.p} !== 18'd0) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL reset_hold: nonzero samples=%0d, required 0", bad);
    end
    bus.start = 1'b0;
    rest      = 1'b0;
    tick();
    checks++;
    if (bus.busy !== 1'b0 || bus.p !== 16'd0) begin
      failures++;
      $display("FAIL reset_no_accept: busy=%b p=%0d, required 0 0", bus.busy, bus.p);
    end
  endtask

  task automatic test_early_exit();
    int cyc;
`ifdef SHIFT_ADD_MULT_EARLY_EXIT_EN
    localparam int LAT_B1 = 1;
    localparam int LAT_B0 = 1;
`else
    localparam int LAT_B1 = 8;
    localparam int LAT_B0 = 8;
`endif
    issue(8'd77, 8'd1);
    wait_done(cyc);
    checks++;
    if (cyc != LAT_B1 || bus.p !== 16'd77) begin
      failures++;
      $display("FAIL exit_b1: cycles=%0d p=%0d, required %0d 77", cyc, bus.p, LAT_B1);
    end
    tick();
    issue(8'd3, 8'h80);
    wait_done(cyc);
    checks++;
    if (cyc != 8 || bus.p !== 16'd384) begin
      failures++;
      $display("FAIL exit_b80: cycles=%0d p=%0d, required 8 384", cyc, bus.p);
    end
    tick();
    issue(8'd99, 8'd0);
    wait_done(cyc);
    checks++;
    if (cyc != LAT_B0 || bus.p !== 16'd0) begin
      failures++;
      $display("FAIL exit_b0: cycles=%0d p=%0d, required %0d 0", cyc, bus.p, LAT_B0);
    end
    tick();
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_basic();
    test_back_to_back();
    test_start_while_busy();
    test_reset_mid_run();
    test_reset_values();
    test_early_exit();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
